neuron_mac: RTL and testbench
=============================

# neuron_mac

Streaming multiply-accumulate stage that computes one neuron's pre-activation, x = Σ(data·weight) + bias, in signed Q8.8. It accepts N_INPUTS operand pairs over a valid/ready handshake and accumulates them at full precision. It then rounds and saturates the result to 16 bits and presents it on a valid/ready output. It sits directly upstream of the piecewise-linear sigmoid stage, whose 16-bit Q8.8 `x` input is driven from `out_x`.

## Interface
- `N_INPUTS`, 16: operand pairs per neuron, ≥1.
- `FRAC`, 8: fractional bits of data, weight, bias and `out_x`.
- `ACC_W`, 40: accumulator width. Must be ≥ 32 + clog2(N_INPUTS) + 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: stage accepts the operand pair.
- `in_data` input 16: signed Q8.8 activation.
- `in_weight` input 16: signed Q8.8 weight.
- `in_bias` input 16: signed Q8.8 bias. Sampled only on the first beat of a neuron.
- `out_valid` output 1: `out_x` valid.
- `out_ready` input 1: consumer accepts `out_x`.
- `out_x` output 16: signed Q8.8 pre-activation, rounded and saturated.
- `out_sat` output 1: `out_x` was clipped. Valid alongside `out_x`.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ACC, DRAIN, FINAL, HOLD.
- IDLE:
  - `in_ready`=1; the accumulator is considered cleared.
  - On a beat (`in_valid`&&`in_ready`): register the product, load acc ← sign_ext(`in_bias`) <<< FRAC, set count=1, go to ACC.
  - If N_INPUTS=1, go to DRAIN instead.
- ACC:
  - `in_ready`=1.
  - On each beat: register the new product, add the previous product into acc, increment count.
  - The beat with count = N_INPUTS−1 moves the FSM to DRAIN.
  - Cycles with `in_valid`=0 are bubbles; acc and count hold, and the pending product is still added exactly once.
- DRAIN: `in_ready`=0; add the last product into acc.
- FINAL:
  - `in_ready`=0.
  - r = (acc + 2^(FRAC−1)) >>> FRAC (arithmetic shift; round half up toward +∞).
  - If r > 32767, `out_x`=0x7FFF; if r < −32768, `out_x`=0x8000. Either case sets `out_sat`=1; otherwise `out_x`=r[15:0] and `out_sat`=0.
  - Go to HOLD.
- HOLD:
  - `out_valid`=1; `in_ready`=0.
  - `out_x` and `out_sat` are stable until `out_valid`&&`out_ready`, then go to IDLE.
- Products are a full 32-bit signed Q16.16 value, sign-extended to ACC_W. The accumulator never wraps within its legal width.
- Operand pairs of the next neuron are not accepted until HOLD completes.

## Timing
- Reset values: `in_ready`=0 during the reset cycle, then 1 in IDLE. `out_valid`=0, `out_x`=0, `out_sat`=0, `busy`=0; FSM=IDLE, count=0, acc=0.
- A product is registered on the accepting edge and added into acc on the next edge.
- Latency: last beat accepted at edge E. Edge E+1 is DRAIN (acc complete), E+2 is FINAL (`out_x` registered), and `out_valid`=1 from E+2.
- The handshake completes at edge H when `out_valid`&&`out_ready`. `out_valid`=0 and `in_ready`=1 from H.
- Minimum period per neuron is N_INPUTS+3 cycles with no back-pressure.
- `out_ready` is ignored while `out_valid`=0. `in_valid` is ignored while `in_ready`=0.
- `rst` wins over everything, including mid-accumulation and HOLD. All partial state is discarded and nothing is emitted.
- The downstream sigmoid stage adds 1 cycle. Its pipeline is unstalled, so the consumer asserts `out_ready` continuously or gates its own capture.

## Structure
- Package `nn_fixed_pkg`:
  - FRAC and the Q8.8 width constant (16).
  - Product width (32).
  - Saturation limits 0x7FFF / 0x8000.
  - FSM state enum.
- Sub-module `round_sat`: combinational. Maps ACC_W-bit acc to 16-bit `out_x` plus `out_sat` using the FRAC shift and half-up rounding. It is reusable by the other Q8.8 stages.
- Top level holds the FSM, count, product register and accumulator.

## Test plan
- N=4, bias 0, four beats of data 0x0100 with weight 0x0100 → `out_x`=0x0400, `out_sat`=0, `out_valid` 2 edges after the last beat.
- N=4, data 0xFF00, weight 0x0100 ×4, bias 0x0080 → `out_x`=0xFC80 (−3.5), `out_sat`=0.
- N=4, data 0x7FFF, weight 0x7FFF ×4 → `out_x`=0x7FFF, `out_sat`=1. Negating the weight (0x8001) gives `out_x`=0x8000, `out_sat`=1.
- Rounding, N=4, bias 0:
  - One beat 0x0001·0x0080 plus three zero beats → `out_x`=0x0001.
  - One beat 0xFFFF·0x0080 plus zeros → `out_x`=0x0000.
- Bubbles and back-pressure: alternate `in_valid` 1/0 across the beats; hold `out_ready`=0 for 5 cycles. Required: same result as without bubbles, and `out_x` stable with `in_ready`=0 throughout HOLD.
- Reset mid-operation: assert `rst` after 2 of 4 beats → `out_valid` stays 0. The next full 4-beat neuron yields the correct result with no residue from the first.

Source files
------------

// File: rtl/nn_fixed_pkg.sv
// Shared Q8.8 fixed-point constants and the MAC state encoding used by the
// neuron datapath stages.
package nn_fixed_pkg;
    localparam int FRAC   = 8;
    localparam int Q_W    = 16;
    localparam int PROD_W = 32;

    localparam logic [Q_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        DRAIN,
        FINAL,
        HOLD
    } state_t;
endpackage

// File: rtl/round_sat.sv
// Wide accumulator to Q8.8: drop FRAC bits with round-half-up, then clip to
// the signed 16-bit range and flag any clipping.
module round_sat #(
    parameter int ACC_W = 40,
    parameter int FRAC  = 8
) (
    input  logic [ACC_W-1:0] acc,
    output logic [15:0]      x,
    output logic             sat
);
    import nn_fixed_pkg::*;

    // One guard bit so adding the half-LSB can never wrap.
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] HALF  = SW'(1) <<< (FRAC - 1);
    localparam logic signed [SW-1:0] R_MAX = SW'(32767);
    localparam logic signed [SW-1:0] R_MIN = SW'(-32768);

    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] r;

    assign sum = $signed({acc[ACC_W-1], acc}) + HALF;
    assign r   = sum >>> FRAC;

    always_comb begin
        x   = r[15:0];
        sat = 1'b0;
        if (r > R_MAX) begin
            x   = SAT_MAX;
            sat = 1'b1;
        end else if (r < R_MIN) begin
            x   = SAT_MIN;
            sat = 1'b1;
        end
    end
endmodule

// File: rtl/neuron_mac.sv
// One neuron's pre-activation: bias plus N_INPUTS data*weight products,
// accumulated at full width, then rounded/saturated to Q8.8 on valid/ready.
module neuron_mac #(
    parameter int N_INPUTS = 16,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] in_weight,
    input  logic [15:0] in_bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x,
    output logic        out_sat,
    output logic        busy
);
    import nn_fixed_pkg::*;

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                   state;
    logic [CNT_W-1:0]         count;
    logic signed [PROD_W-1:0] prod;
    logic                     pend;
    logic signed [ACC_W-1:0]  acc;

    logic                     beat;
    logic signed [PROD_W-1:0] prod_nxt;
    logic signed [ACC_W-1:0]  acc_add;
    logic signed [ACC_W-1:0]  bias_ext;
    logic [15:0]              rs_x;
    logic                     rs_sat;

    assign in_ready = !rst && (state == IDLE || state == ACC);
    assign busy     = (state != IDLE);
    assign beat     = in_valid && in_ready;
    assign prod_nxt = $signed(in_data) * $signed(in_weight);
    assign bias_ext = $signed({{(ACC_W-Q_W){in_bias[15]}}, in_bias}) <<< FRAC;
    // Product is pipelined one edge; pend marks it as not yet summed.
    assign acc_add  = pend ? $signed({{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod}) : '0;

    round_sat #(.ACC_W(ACC_W), .FRAC(FRAC)) u_round_sat (
        .acc (acc),
        .x   (rs_x),
        .sat (rs_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            prod      <= '0;
            pend      <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (beat) begin
                    prod  <= prod_nxt;
                    pend  <= 1'b1;
                    acc   <= bias_ext;
                    count <= CNT_W'(1);
                    state <= (N_INPUTS == 1) ? DRAIN : ACC;
                end
                ACC: begin
                    acc <= acc + acc_add;
                    if (beat) begin
                        prod  <= prod_nxt;
                        pend  <= 1'b1;
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(N_INPUTS - 1))
                            state <= DRAIN;
                    end else begin
                        pend <= 1'b0;
                    end
                end
                DRAIN: begin
                    acc   <= acc + acc_add;
                    pend  <= 1'b0;
                    state <= FINAL;
                end
                FINAL: begin
                    out_x     <= rs_x;
                    out_sat   <= rs_sat;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    count     <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_INPUTS=4: latency, rounding,
// saturation, bubbles, back-pressure and mid-neuron reset.
module tb_neuron_mac;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_weight;
    logic [15:0] in_bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_sat;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    neuron_mac #(.N_INPUTS(4), .FRAC(8), .ACC_W(40)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .in_bias   (in_bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
        int n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_weight = w;
        in_bias   = b;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("beat_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Bias goes out on beat 0 only; later beats carry junk there on purpose.
    task automatic run(input string tag, input logic [3:0][15:0] d, input logic [3:0][15:0] w,
                       input logic [15:0] bias, input bit bub, input int hold,
                       input logic [15:0] exp_x, input logic exp_sat);
        out_ready = (hold == 0);
        for (int i = 0; i < 4; i++) begin
            beat(d[i], w[i], (i == 0) ? bias : 16'hDEAD);
            if (bub && i < 3) tick();
        end
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_vld_e0"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_vld_e1"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_vld_e2"}, 32'(out_valid), 32'd1);
        chk({tag, "_rdy_hold"}, 32'(in_ready), 32'd0);
        chk({tag, "_x"}, 32'(out_x), 32'(exp_x));
        chk({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h1234;
            tick();
            chk({tag, "_stall_x"}, 32'(out_x), 32'(exp_x));
            chk({tag, "_stall_vld"}, 32'(out_valid), 32'd1);
            chk({tag, "_stall_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk({tag, "_vld_done"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_done"}, 32'(in_ready), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    logic [3:0][15:0] d, w;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_weight = '0; in_bias = '0;
        out_ready = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_x", 32'(out_x), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        d = {4{16'h0100}}; w = {4{16'h0100}};
        run("ones", d, w, 16'h0000, 1'b0, 0, 16'h0400, 1'b0);

        d = {4{16'hFF00}}; w = {4{16'h0100}};
        run("neg", d, w, 16'h0080, 1'b0, 0, 16'hFC80, 1'b0);

        d = {4{16'h7FFF}}; w = {4{16'h7FFF}};
        run("satp", d, w, 16'h0000, 1'b0, 0, 16'h7FFF, 1'b1);

        w = {4{16'h8001}};
        run("satn", d, w, 16'h0000, 1'b0, 0, 16'h8000, 1'b1);

        d = {16'h0, 16'h0, 16'h0, 16'h0001}; w = {16'h0, 16'h0, 16'h0, 16'h0080};
        run("rnd_up", d, w, 16'h0000, 1'b0, 0, 16'h0001, 1'b0);

        d = {16'h0, 16'h0, 16'h0, 16'hFFFF};
        run("rnd_neg", d, w, 16'h0000, 1'b0, 0, 16'h0000, 1'b0);

        d = {16'h0, 16'h0, 16'h0, 16'h0001}; w = {16'h0, 16'h0, 16'h0, 16'h007F};
        run("rnd_dn", d, w, 16'h0000, 1'b0, 0, 16'h0000, 1'b0);

        d = {4{16'hFF00}}; w = {4{16'h0100}};
        run("bub", d, w, 16'h0080, 1'b1, 5, 16'hFC80, 1'b0);

        // Two beats of a large-bias neuron, then reset: nothing may leak out.
        beat(16'h0100, 16'h0100, 16'h7F00);
        beat(16'h0100, 16'h0100, 16'hDEAD);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_rst_vld", 32'(out_valid), 32'd0);
        end
        d = {4{16'h0100}}; w = {4{16'h0100}};
        run("after_rst", d, w, 16'h0000, 1'b0, 0, 16'h0400, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
